bank_arbiter: RTL and testbench

//  Shares one 128x128 bank (1 write port, 1 read port) between NUM_REQ clients.

---
 rtl/bank_arb_pkg.sv | 19 +
 rtl/bank_arbiter_if.sv | 29 ++
 rtl/bank_arbiter_rr.sv | 47 ++++
 rtl/bank_arbiter.sv | 121 ++++++++++++
 tb/tb_bank_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bank_arb_pkg.sv
// Shared defaults and types for the bank arbiter.
// The read tag carries the issuing client id. When BANK_ARB_WR_FWD_EN is
// defined, it also carries write data forwarded from a same-cycle collision.
package bank_arb_pkg;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_ADDR_W  = 7;
   localparam int DEF_DATA_W  = 128;
   localparam int DEF_RD_LAT  = 1;
   localparam int ID_W        = $clog2(DEF_NUM_REQ);

   typedef struct packed {
      logic                  valid;
      logic [ID_W-1:0]       id;
      logic                  fwd;
      logic [DEF_DATA_W-1:0] fwd_data;
   } rd_tag_t;

endpackage

// File: rtl/bank_arbiter_if.sv
// Client-side bundle of the bank arbiter: write/read request channels and the
// read response. The clients drive the master side; the arbiter is the slave.
interface bank_arbiter_if
   import bank_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W
);
   logic [NUM_REQ-1:0]        wr_valid;
   logic [NUM_REQ-1:0]        wr_ready;
   logic [NUM_REQ*ADDR_W-1:0] wr_addr;
   logic [NUM_REQ*DATA_W-1:0] wr_data;
   logic [NUM_REQ-1:0]        rd_valid;
   logic [NUM_REQ-1:0]        rd_ready;
   logic [NUM_REQ*ADDR_W-1:0] rd_addr;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_data;

   modport master (
      output wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
      input  wr_ready, rd_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
      output wr_ready, rd_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/bank_arbiter_rr.sv
// Round-robin arbiter: the grant goes to the first valid requester at or
// after the pointer. The pointer moves past the winner only when the caller
// reports that the grant was actually used (advance).
module rr_arbiter #(
   parameter int NUM_REQ = 4
)(
   input  logic               clk,
   input  logic               srst,
   input  logic [NUM_REQ-1:0] valid,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant
);
   localparam int IDX_W = $clog2(NUM_REQ);

   logic [IDX_W-1:0] ptr_reg, ptr_next, win;
   logic             found;
   logic [IDX_W-1:0] idx;
   int               sum;

   // Search from the pointer with wrap-around, and compute the next pointer
   always_comb begin
      grant = '0;
      win   = '0;
      found = 1'b0;
      idx   = '0;
      sum   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = int'(ptr_reg) + k;
         if (sum >= NUM_REQ) sum = sum - NUM_REQ;
         idx = IDX_W'(sum);
         if (!found && valid[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            win        = idx;
         end
      end
      ptr_next = ptr_reg;
      if (advance && found)
         ptr_next = (win == IDX_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
   end

   // Pointer register
   always_ff @(posedge clk) begin
      if (srst) ptr_reg <= '0;
      else      ptr_reg <= ptr_next;
   end
endmodule

// File: rtl/bank_arbiter.sv
// Shares one bank (single write port, single read port) among NUM_REQ clients.
// Writes and reads each use their own round-robin arbiter.
// Reads are tagged with the client id, and the bank data is routed back to
// that client RD_LAT cycles after the grant.
// Optional macro BANK_ARB_WR_FWD_EN controls read/write collisions at the same address:
//   - Defined: the read is granted in the same cycle, and the write data is forwarded as the response.
//   - Undefined: the read is held off for one cycle and then reads the new data.
module bank_arbiter
   import bank_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int RD_LAT  = DEF_RD_LAT
)(
   input  logic              vsi_clk,
   input  logic              vsi_reset,
   bank_arbiter_if.slave     cli,
   output logic              bank_inputChipSelect,
   output logic [ADDR_W-1:0] bank_inputAddr,
   output logic [DATA_W-1:0] bank_inputData,
   output logic              bank_outputChipSelect,
   output logic [ADDR_W-1:0] bank_outputAddr,
   input  logic [DATA_W-1:0] bank_outputData
);
   logic [ADDR_W-1:0]  wr_addr_a [NUM_REQ];
   logic [DATA_W-1:0]  wr_data_a [NUM_REQ];
   logic [ADDR_W-1:0]  rd_addr_a [NUM_REQ];
   logic [NUM_REQ-1:0] wr_vld, rd_vld, wr_grant, rd_cand, rd_grant;
   logic [ID_W-1:0]    wr_idx, rd_idx;
   logic               wr_fire, rd_fire, collision, fwd_hit;
   rd_tag_t            tag_in, tag_out;
   rd_tag_t            tag_reg [RD_LAT];
   logic               rsp_live;
   logic [DATA_W-1:0]  rsp_new, rsp_data_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign wr_addr_a[gi] = cli.wr_addr[gi*ADDR_W +: ADDR_W];
         assign wr_data_a[gi] = cli.wr_data[gi*DATA_W +: DATA_W];
         assign rd_addr_a[gi] = cli.rd_addr[gi*ADDR_W +: ADDR_W];
      end
   endgenerate

   // Masking requests during reset keeps every grant and bank strobe low
   assign wr_vld = vsi_reset ? '0 : cli.wr_valid;
   assign rd_vld = vsi_reset ? '0 : cli.rd_valid;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
      .clk(vsi_clk), .srst(vsi_reset), .valid(wr_vld),
      .advance(wr_fire), .grant(wr_grant)
   );

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
      .clk(vsi_clk), .srst(vsi_reset), .valid(rd_vld),
      .advance(rd_fire), .grant(rd_cand)
   );

   // One-hot to index for both winners, plus collision detection and read gating
   always_comb begin
      wr_idx = '0;
      rd_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (wr_grant[i]) wr_idx = ID_W'(i);
         if (rd_cand[i])  rd_idx = ID_W'(i);
      end
      wr_fire   = |wr_grant;
      collision = wr_fire && (|rd_cand) && (rd_addr_a[rd_idx] == wr_addr_a[wr_idx]);
`ifdef BANK_ARB_WR_FWD_EN
      rd_grant = rd_cand;
      fwd_hit  = collision;
`else
      rd_grant = collision ? '0 : rd_cand;
      fwd_hit  = 1'b0;
`endif
      rd_fire = |rd_grant;
   end

   assign cli.wr_ready = wr_grant;
   assign cli.rd_ready = rd_grant;

   assign bank_inputChipSelect  = wr_fire;
   assign bank_inputAddr        = wr_fire ? wr_addr_a[wr_idx] : '0;
   assign bank_inputData        = wr_fire ? wr_data_a[wr_idx] : '0;
   assign bank_outputChipSelect = rd_fire;
   assign bank_outputAddr       = rd_fire ? rd_addr_a[rd_idx] : '0;

   assign tag_in.valid    = rd_fire;
   assign tag_in.id       = rd_idx;
   assign tag_in.fwd      = fwd_hit;
   assign tag_in.fwd_data = fwd_hit ? wr_data_a[wr_idx] : '0;

   // Tag shift register that matches the bank read latency
   always_ff @(posedge vsi_clk) begin
      if (vsi_reset) begin
         for (int i = 0; i < RD_LAT; i++) tag_reg[i] <= '0;
      end else begin
         tag_reg[0] <= tag_in;
         for (int i = 1; i < RD_LAT; i++) tag_reg[i] <= tag_reg[i-1];
      end
   end

   assign tag_out  = tag_reg[RD_LAT-1];
   assign rsp_live = tag_out.valid && !vsi_reset;
   assign rsp_new  = tag_out.fwd ? tag_out.fwd_data : bank_outputData;

   // Hold the last response, so rsp_data is stable between responses
   always_ff @(posedge vsi_clk) begin
      if (vsi_reset)     rsp_data_reg <= '0;
      else if (rsp_live) rsp_data_reg <= rsp_new;
   end

   assign cli.rsp_data = rsp_live ? rsp_new : rsp_data_reg;

   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
         assign cli.rsp_valid[gi] = rsp_live && (tag_out.id == ID_W'(gi));
      end
   endgenerate
endmodule

// File: tb/tb_bank_arbiter.sv
// Directed testbench for bank_arbiter: reset, write/read, round-robin,
// collision, reset during a read, and streaming reads.
// The bench contains a simple 128x128 read-first bank model with a 1-cycle read.
module tb_bank_arbiter;
   localparam int N  = 4;
   localparam int AW = 7;
   localparam int DW = 128;

   logic          clk = 1'b0;
   logic          vsi_reset;
   logic          bank_inputChipSelect, bank_outputChipSelect;
   logic [AW-1:0] bank_inputAddr, bank_outputAddr;
   logic [DW-1:0] bank_inputData;
   logic [DW-1:0] bank_outputData = '0;
   logic [DW-1:0] mem [128];
   int            n_vec = 0;
   int            n_err = 0;

   always #5 clk = ~clk;

   bank_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) cli ();

   bank_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
      .vsi_clk(clk), .vsi_reset(vsi_reset), .cli(cli),
      .bank_inputChipSelect(bank_inputChipSelect), .bank_inputAddr(bank_inputAddr),
      .bank_inputData(bank_inputData), .bank_outputChipSelect(bank_outputChipSelect),
      .bank_outputAddr(bank_outputAddr), .bank_outputData(bank_outputData)
   );

   // Bank model: the read samples the old contents when a write hits the same address
   always @(posedge clk) begin
      if (bank_outputChipSelect) bank_outputData <= mem[bank_outputAddr];
      if (bank_inputChipSelect)  mem[bank_inputAddr] <= bank_inputData;
   end

   function automatic logic [DW-1:0] pat(input int k);
      logic [31:0] w;
      w = 32'hC0DE_0000 + 32'(k);
      return {w, ~w, w, ~w};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_all();
      cli.wr_valid = '0; cli.rd_valid = '0;
      cli.wr_addr  = '0; cli.wr_data  = '0; cli.rd_addr = '0;
   endtask

   task automatic do_reset();
      vsi_reset = 1'b1;
      clear_all();
      tick();
      vsi_reset = 1'b0;
   endtask

   task automatic test_reset();
      vsi_reset    = 1'b1;
      cli.wr_valid = '1;
      cli.rd_valid = '1;
      for (int i = 0; i < N; i++) begin
         cli.wr_addr[i*AW +: AW] = AW'(i);
         cli.rd_addr[i*AW +: AW] = AW'(i + 8);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_vec++;
         if ({cli.wr_ready, cli.rd_ready} !== 8'h00) begin
            n_err++;
            $display("FAIL reset.ready cyc%0d got wr=%b rd=%b want 0000/0000", c, cli.wr_ready, cli.rd_ready);
         end
         n_vec++;
         if ({bank_inputChipSelect, bank_outputChipSelect, cli.rsp_valid} !== 6'b0) begin
            n_err++;
            $display("FAIL reset.cs_rsp cyc%0d got wcs=%b rcs=%b rsp_valid=%b want 0/0/0000", c,
                     bank_inputChipSelect, bank_outputChipSelect, cli.rsp_valid);
         end
         tick();
      end
      vsi_reset = 1'b0;
      clear_all();
      @(negedge clk);
      n_vec++;
      if (cli.rsp_valid !== 4'b0000 || cli.rsp_data !== '0) begin
         n_err++;
         $display("FAIL reset.rsp got valid=%b data=%h want 0000/0", cli.rsp_valid, cli.rsp_data);
      end
      tick();
   endtask

   task automatic test_write_read();
      cli.wr_valid = 4'b0001;
      cli.wr_addr[0 +: AW] = 7'd1;
      cli.wr_data[0 +: DW] = 128'habcd123;
      @(negedge clk);
      n_vec++;
      if (cli.wr_ready !== 4'b0001 || bank_inputChipSelect !== 1'b1 ||
          bank_inputAddr !== 7'd1 || bank_inputData !== 128'habcd123) begin
         n_err++;
         $display("FAIL wr_rd.write got ready=%b cs=%b addr=%0d data=%h want 0001/1/1/abcd123",
                  cli.wr_ready, bank_inputChipSelect, bank_inputAddr, bank_inputData);
      end
      tick();
      clear_all();
      cli.rd_valid = 4'b0010;
      cli.rd_addr[1*AW +: AW] = 7'd1;
      @(negedge clk);
      n_vec++;
      if (cli.rd_ready !== 4'b0010 || bank_outputChipSelect !== 1'b1 || bank_outputAddr !== 7'd1) begin
         n_err++;
         $display("FAIL wr_rd.read got ready=%b cs=%b addr=%0d want 0010/1/1",
                  cli.rd_ready, bank_outputChipSelect, bank_outputAddr);
      end
      tick();
      clear_all();
      @(negedge clk);
      n_vec++;
      if (cli.rsp_valid !== 4'b0010 || cli.rsp_data !== 128'habcd123) begin
         n_err++;
         $display("FAIL wr_rd.rsp got valid=%b data=%h want 0010/abcd123", cli.rsp_valid, cli.rsp_data);
      end
      tick();
      @(negedge clk);
      n_vec++;
      if (cli.rsp_valid !== 4'b0000 || cli.rsp_data !== 128'habcd123) begin
         n_err++;
         $display("FAIL wr_rd.hold got valid=%b data=%h want 0000/abcd123", cli.rsp_valid, cli.rsp_data);
      end
      tick();
   endtask

   task automatic test_round_robin();
      logic [N-1:0] exp;
      do_reset();
      cli.wr_valid = '1;
      for (int i = 0; i < N; i++) begin
         cli.wr_addr[i*AW +: AW] = AW'(10 + i);
         cli.wr_data[i*DW +: DW] = DW'(i);
      end
      for (int c = 0; c < 8; c++) begin
         exp = 4'(1 << (c % 4));
         @(negedge clk);
         n_vec++;
         if (cli.wr_ready !== exp || bank_inputAddr !== AW'(10 + c % 4)) begin
            n_err++;
            $display("FAIL rr.grant cyc%0d got ready=%b addr=%0d want %b/%0d",
                     c, cli.wr_ready, bank_inputAddr, exp, 10 + c % 4);
         end
         tick();
      end
      clear_all();
   endtask

   task automatic test_collision();
      do_reset();
      cli.wr_valid = 4'b0100;
      cli.wr_addr[2*AW +: AW] = 7'd2;
      cli.wr_data[2*DW +: DW] = 128'h1234abcd;
      cli.rd_valid = 4'b1000;
      cli.rd_addr[3*AW +: AW] = 7'd2;
      @(negedge clk);
      n_vec++;
      if (cli.wr_ready !== 4'b0100 || bank_inputChipSelect !== 1'b1) begin
         n_err++;
         $display("FAIL coll.write got ready=%b cs=%b want 0100/1", cli.wr_ready, bank_inputChipSelect);
      end
`ifdef BANK_ARB_WR_FWD_EN
      n_vec++;
      if (cli.rd_ready !== 4'b1000 || bank_outputChipSelect !== 1'b1) begin
         n_err++;
         $display("FAIL coll.read_same got ready=%b cs=%b want 1000/1", cli.rd_ready, bank_outputChipSelect);
      end
      tick();
      clear_all();
`else
      n_vec++;
      if (cli.rd_ready !== 4'b0000 || bank_outputChipSelect !== 1'b0) begin
         n_err++;
         $display("FAIL coll.read_stall got ready=%b cs=%b want 0000/0", cli.rd_ready, bank_outputChipSelect);
      end
      tick();
      cli.wr_valid = '0;
      @(negedge clk);
      n_vec++;
      if (cli.rd_ready !== 4'b1000 || bank_outputAddr !== 7'd2) begin
         n_err++;
         $display("FAIL coll.read_next got ready=%b addr=%0d want 1000/2", cli.rd_ready, bank_outputAddr);
      end
      tick();
      clear_all();
`endif
      @(negedge clk);
      n_vec++;
      if (cli.rsp_valid !== 4'b1000 || cli.rsp_data !== 128'h1234abcd) begin
         n_err++;
         $display("FAIL coll.rsp got valid=%b data=%h want 1000/1234abcd", cli.rsp_valid, cli.rsp_data);
      end
      tick();
   endtask

   task automatic test_reset_mid_read();
      clear_all();
      cli.rd_valid = 4'b0100;
      cli.rd_addr[2*AW +: AW] = 7'd1;
      @(negedge clk);
      n_vec++;
      if (cli.rd_ready !== 4'b0100) begin
         n_err++;
         $display("FAIL rst_mid.grant got ready=%b want 0100", cli.rd_ready);
      end
      tick();
      cli.rd_valid = '0;
      vsi_reset    = 1'b1;
      @(negedge clk);
      n_vec++;
      if (cli.rsp_valid !== 4'b0000) begin
         n_err++;
         $display("FAIL rst_mid.rsp_in_reset got valid=%b want 0000", cli.rsp_valid);
      end
      tick();
      vsi_reset    = 1'b0;
      cli.rd_valid = '1;
      cli.wr_valid = '1;
      for (int i = 0; i < N; i++) begin
         cli.rd_addr[i*AW +: AW] = AW'(i);
         cli.wr_addr[i*AW +: AW] = AW'(100 + i);
      end
      @(negedge clk);
      n_vec++;
      if (cli.rsp_valid !== 4'b0000) begin
         n_err++;
         $display("FAIL rst_mid.rsp_after got valid=%b want 0000", cli.rsp_valid);
      end
      n_vec++;
      if (cli.rd_ready !== 4'b0001 || cli.wr_ready !== 4'b0001) begin
         n_err++;
         $display("FAIL rst_mid.ptr got rd=%b wr=%b want 0001/0001", cli.rd_ready, cli.wr_ready);
      end
      tick();
      clear_all();
      tick();
   endtask

   task automatic test_streaming();
      int           c;
      int           prev_c;
      logic [N-1:0] exp;
      c = 0;
      prev_c = 0;
      clear_all();
      for (int k = 0; k < 16; k++) begin
         cli.wr_valid = 4'b0001;
         cli.wr_addr[0 +: AW] = AW'(32 + k);
         cli.wr_data[0 +: DW] = pat(k);
         tick();
      end
      clear_all();
      for (int k = 0; k <= 17; k++) begin
         if (k < 16) begin
            c = (k % 2 == 0) ? 0 : 3;
            cli.rd_valid = 4'(1 << c);
            cli.rd_addr[c*AW +: AW] = AW'(32 + k);
         end else begin
            cli.rd_valid = '0;
         end
         @(negedge clk);
         if (k < 16) begin
            exp = 4'(1 << c);
            n_vec++;
            if (cli.rd_ready !== exp || bank_outputAddr !== AW'(32 + k)) begin
               n_err++;
               $display("FAIL stream.grant k%0d got ready=%b addr=%0d want %b/%0d",
                        k, cli.rd_ready, bank_outputAddr, exp, 32 + k);
            end
         end
         if (k >= 1 && k <= 16) begin
            exp = 4'(1 << prev_c);
            n_vec++;
            if (cli.rsp_valid !== exp || cli.rsp_data !== pat(k - 1)) begin
               n_err++;
               $display("FAIL stream.rsp k%0d got valid=%b data=%h want %b/%h",
                        k - 1, cli.rsp_valid, cli.rsp_data, exp, pat(k - 1));
            end
         end
         if (k == 17) begin
            n_vec++;
            if (cli.rsp_valid !== 4'b0000) begin
               n_err++;
               $display("FAIL stream.end got valid=%b want 0000", cli.rsp_valid);
            end
         end
         prev_c = c;
         tick();
      end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = '0;
      vsi_reset = 1'b1;
      clear_all();
      test_reset();
      test_write_read();
      test_round_robin();
      test_collision();
      test_reset_mid_read();
      test_streaming();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
